// File: rtl/lot_draw_if.sv
// Bundle of the lottery-draw request/result signals shared between the draw
// engine and whatever drives it.
interface lot_draw_if;
    logic        sorteia;
    logic        lido;
    logic        fixo;
    logic [19:0] num_fixo;
    logic        carrega;
    logic [15:0] semente;
    logic [19:0] sorteado;
    logic        valido;
    logic        ocupado;
    logic [2:0]  ndig;
    logic [1:0]  state;

    modport master (
        output sorteia, lido, fixo, num_fixo, carrega, semente,
        input  sorteado, valido, ocupado, ndig, state
    );

    modport slave (
        input  sorteia, lido, fixo, num_fixo, carrega, semente,
        output sorteado, valido, ocupado, ndig, state
    );
endinterface

// File: rtl/lot_draw.sv
// Five-digit BCD lottery draw: digits are taken from a free-running LFSR,
// rejecting nibbles above 9, or loaded directly in fixed-draw mode.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for sorteia; last result stays on sorteado
// DRAW  | accepting LFSR nibbles until five BCD digits are collected
// HOLD  | complete number presented (valido) until lido
module lot_draw (
    input  logic       clk,
    input  logic       reset,
    lot_draw_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    state_t      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [19:0] sorteado_q;
    logic [2:0]  ndig_q;
    logic        valido_q;
    logic        ocupado_q;
    logic        lfsr_fb;

    // Taps 16,14,13,11; a zero seed is replaced so the register never locks up.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        if (bus.carrega) begin
            lfsr_d = (bus.semente == 16'h0000) ? SEED_DEFAULT : bus.semente;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sorteado_q <= 20'h00000;
            ndig_q     <= 3'd0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.sorteia) begin
                        if (bus.fixo) begin
                            sorteado_q <= bus.num_fixo;
                            ndig_q     <= 3'd5;
                            state_q    <= HOLD;
                            valido_q   <= 1'b1;
                            ocupado_q  <= 1'b0;
                        end else begin
                            sorteado_q <= 20'h00000;
                            ndig_q     <= 3'd0;
                            state_q    <= DRAW;
                            valido_q   <= 1'b0;
                            ocupado_q  <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    // The nibble is taken from the current LFSR value, so a
                    // coincident reseed only affects later digits.
                    if (lfsr_q[3:0] <= 4'd9) begin
                        sorteado_q <= {sorteado_q[15:0], lfsr_q[3:0]};
                        ndig_q     <= ndig_q + 3'd1;
                        if (ndig_q == 3'd4) begin
                            state_q   <= HOLD;
                            valido_q  <= 1'b1;
                            ocupado_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.lido) begin
                        state_q  <= IDLE;
                        valido_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    valido_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sorteado = sorteado_q;
    assign bus.valido   = valido_q;
    assign bus.ocupado  = ocupado_q;
    assign bus.ndig     = ndig_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_lot_draw.sv
// Self-checking bench for lot_draw: predicts each random draw from an
// arithmetic LFSR reference and checks fixed draws, handshakes and resets.
module tb_lot_draw;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [15:0] m_lfsr;

    lot_draw_if bus ();

    lot_draw dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] seed_norm(input logic [15:0] s);
        return (s == 16'h0000) ? 16'hACE1 : s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else if (bus.carrega) m_lfsr <= seed_norm(bus.semente);
        else m_lfsr <= lfsr_next(m_lfsr);
    end

    // Walk the LFSR sequence from the first DRAW edge, collecting BCD digits.
    function automatic void predict(input logic [15:0] start, input int reseed_at,
                                    input logic [15:0] reseed,
                                    output logic [19:0] num, output int lat);
        logic [15:0] l;
        int acc;
        l = start; acc = 0; num = 20'h0; lat = 0;
        while (acc < 5 && lat < 1000) begin
            if (l[3:0] <= 4'd9) begin
                num = {num[15:0], l[3:0]};
                acc++;
            end
            l = (lat == reseed_at) ? seed_norm(reseed) : lfsr_next(l);
            lat++;
        end
    endfunction

    function automatic bit all_bcd(input logic [19:0] v);
        for (int i = 0; i < 5; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_draw(input bit load, input logic [15:0] seed, input int reseed_at,
                           input logic [15:0] reseed, input bit hold_req,
                           output logic [19:0] exp);
        int lat;
        bus.fixo = 1'b0; bus.sorteia = 1'b1; bus.carrega = load; bus.semente = seed;
        @(negedge clk);
        bus.sorteia = hold_req; bus.carrega = 1'b0;
        n_cmp++;
        if ({bus.state, bus.ocupado, bus.valido, bus.ndig} !== {2'd1, 1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL draw_start: state=%0d ocupado=%b valido=%b ndig=%0d, required 1/1/0/0",
                     bus.state, bus.ocupado, bus.valido, bus.ndig);
        end
        predict(m_lfsr, reseed_at, reseed, exp, lat);
        for (int c = 0; c < lat; c++) begin
            if (c == reseed_at) begin bus.carrega = 1'b1; bus.semente = reseed; end
            @(negedge clk);
            bus.carrega = 1'b0;
            n_cmp++;
            if ({bus.valido, bus.ocupado} !== {c == lat - 1, c != lat - 1}) begin
                n_err++;
                $display("FAIL draw_step%0d: valido=%b ocupado=%b, required %b/%b (latency %0d)",
                         c, bus.valido, bus.ocupado, c == lat - 1, c != lat - 1, lat);
            end
        end
        n_cmp++;
        if (bus.sorteado !== exp || bus.ndig !== 3'd5 || !all_bcd(bus.sorteado)) begin
            n_err++;
            $display("FAIL draw_result: sorteado=%h ndig=%0d, required %h ndig=5",
                     bus.sorteado, bus.ndig, exp);
        end
    endtask

    task automatic finish_draw();
        bus.lido = 1'b1;
        @(negedge clk);
        bus.lido = 1'b0;
        n_cmp++;
        if ({bus.state, bus.valido, bus.ocupado} !== {2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL lido_release: state=%0d valido=%b ocupado=%b, required 0/0/0",
                     bus.state, bus.valido, bus.ocupado);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sorteia = 0; bus.lido = 0; bus.fixo = 0; bus.num_fixo = 0;
        bus.carrega = 0; bus.semente = 0;
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.state, bus.sorteado, bus.ndig, bus.valido, bus.ocupado} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_values: state=%0d sorteado=%h ndig=%0d valido=%b ocupado=%b, required all 0",
                     bus.state, bus.sorteado, bus.ndig, bus.valido, bus.ocupado);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random_reset_seed();
        logic [19:0] e;
        do_draw(1'b0, 16'h0, -1, 16'h0, 1'b0, e);
        finish_draw();
    endtask

    task automatic test_fixed(input logic [19:0] val);
        bus.fixo = 1'b1; bus.num_fixo = val; bus.sorteia = 1'b1;
        @(negedge clk);
        bus.sorteia = 1'b0;
        n_cmp++;
        if ({bus.valido, bus.sorteado, bus.ndig, bus.state, bus.ocupado} !== {1'b1, val, 3'd5, 2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL fixed_load: valido=%b sorteado=%h ndig=%0d state=%0d, required 1 %h 5 2",
                     bus.valido, bus.sorteado, bus.ndig, bus.state, val);
        end
        for (int i = 0; i < 10; i++) begin
            bus.fixo = 1'($urandom_range(0, 1));
            bus.num_fixo = 20'($urandom);
            bus.sorteia = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp++;
            if ({bus.valido, bus.sorteado, bus.state} !== {1'b1, val, 2'd2}) begin
                n_err++;
                $display("FAIL fixed_hold%0d: valido=%b sorteado=%h state=%0d, required 1 %h 2",
                         i, bus.valido, bus.sorteado, bus.state, val);
            end
        end
        bus.sorteia = 1'b0; bus.fixo = 1'b0;
        finish_draw();
        n_cmp++;
        if (bus.sorteado !== val) begin
            n_err++;
            $display("FAIL fixed_idle_keep: sorteado=%h, required %h", bus.sorteado, val);
        end
    endtask

    task automatic test_zero_seed();
        logic [19:0] e, r1, r2;
        bus.carrega = 1'b1; bus.semente = 16'h0000;
        @(negedge clk);
        bus.carrega = 1'b0;
        do_draw(1'b0, 16'h0, -1, 16'h0, 1'b0, e);
        finish_draw();
        do_draw(1'b1, 16'h1234, -1, 16'h0, 1'b0, r1);
        finish_draw();
        repeat (3) @(negedge clk);
        do_draw(1'b1, 16'h1234, -1, 16'h0, 1'b0, r2);
        finish_draw();
        n_cmp++;
        if (bus.sorteado !== r1) begin
            n_err++;
            $display("FAIL same_seed_repeat: second=%h, required first=%h", bus.sorteado, r1);
        end
    endtask

    task automatic test_reseed_mid_draw();
        logic [19:0] e;
        do_draw(1'b0, 16'h0, 2, 16'(($urandom % 16'hFFFF) + 1), 1'b0, e);
        finish_draw();
    endtask

    task automatic test_handshake();
        logic [19:0] e;
        do_draw(1'b0, 16'h0, -1, 16'h0, 1'b1, e);
        bus.lido = 1'b1;
        @(negedge clk);
        bus.lido = 1'b0; bus.sorteia = 1'b0;
        n_cmp++;
        if ({bus.state, bus.valido, bus.ocupado} !== {2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sorteia_with_lido: state=%0d valido=%b ocupado=%b, required 0/0/0",
                     bus.state, bus.valido, bus.ocupado);
        end
        bus.lido = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.lido = 1'b0;
        n_cmp++;
        if ({bus.state, bus.sorteado, bus.valido} !== {2'd0, e, 1'b0}) begin
            n_err++;
            $display("FAIL lido_in_idle: state=%0d sorteado=%h valido=%b, required 0 %h 0",
                     bus.state, bus.sorteado, bus.valido, e);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        bus.fixo = 1'b0; bus.sorteia = 1'b1;
        @(negedge clk);
        bus.sorteia = 1'b0;
        guard = 0;
        while (bus.ndig != 3'd3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL reach_ndig3: ndig=%0d after %0d cycles, required 3", bus.ndig, guard);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.sorteado, bus.ndig, bus.state, bus.ocupado, bus.valido} !== 27'd0) begin
            n_err++;
            $display("FAIL async_reset_mid: sorteado=%h ndig=%0d state=%0d ocupado=%b, required all 0",
                     bus.sorteado, bus.ndig, bus.state, bus.ocupado);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.state, bus.valido} !== {2'd0, 1'b0}) begin
                n_err++;
                $display("FAIL post_reset_idle%0d: state=%0d valido=%b, required 0/0",
                         i, bus.state, bus.valido);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e;
        logic [15:0] s;
        bit ld;
        for (int i = 0; i < 1000; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            s  = 16'($urandom);
            if ($urandom_range(0, 15) == 0) s = 16'h0000;
            do_draw(ld, s, -1, 16'h0, 1'b0, e);
            finish_draw();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_random_reset_seed();
        test_fixed(20'h47010);
        test_fixed(20'hFABCD);
        test_zero_seed();
        test_reseed_mid_draw();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
